// File: rtl/interrupt_interface.sv
`default_nettype none
// ============================================================================
// interrupt_interface: registers CLINT/external requests into mip, masks and
// priority-encodes them, and offers one interrupt to commit via req/ack.
// Revision: 1.0
// ============================================================================
module interrupt_interface #(
    parameter int EXT_SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        all_intif_int_software_req,
    input  logic        all_intif_int_timer_req,
    input  logic        all_intif_int_ext_req,
    input  logic [31:0] csrf_intif_mie_data,
    input  logic        csrf_intif_mstatus_mie,
    input  logic        commit_intif_ack,
    output logic [31:0] intif_csrf_mip_data,
    output logic        intif_commit_has_interrupt,
    output logic [31:0] intif_commit_mcause_data
);

    localparam logic [3:0] C_CODE_MSI = 4'd3;
    localparam logic [3:0] C_CODE_MTI = 4'd7;
    localparam logic [3:0] C_CODE_MEI = 4'd11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_ACKED = 2'd2
    } state_t;

    logic                       r_msip;
    logic                       r_mtip;
    logic [EXT_SYNC_STAGES-1:0] r_ext_sync;
    state_t                     r_state;
    logic [3:0]                 r_code;
    logic                       r_has_interrupt;
    logic [31:0]                r_mcause;

    logic [31:0] w_mip;
    logic [31:0] w_pending;
    logic [3:0]  w_best_code;
    logic        w_latched_pending;

    // External request is asynchronous; only the last synchroniser flop is used.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_msip     <= 1'b0;
            r_mtip     <= 1'b0;
            r_ext_sync <= '0;
        end else begin
            r_msip     <= all_intif_int_software_req;
            r_mtip     <= all_intif_int_timer_req;
            r_ext_sync <= {r_ext_sync[EXT_SYNC_STAGES-2:0], all_intif_int_ext_req};
        end
    end

    assign w_mip = {20'b0, r_ext_sync[EXT_SYNC_STAGES-1], 3'b0, r_mtip, 3'b0, r_msip, 3'b0};

    assign w_pending = w_mip & csrf_intif_mie_data & {32{csrf_intif_mstatus_mie}};

    always_comb begin
        w_best_code = 4'd0;
        if (w_pending[11]) begin
            w_best_code = C_CODE_MEI;
        end else if (w_pending[3]) begin
            w_best_code = C_CODE_MSI;
        end else if (w_pending[7]) begin
            w_best_code = C_CODE_MTI;
        end
    end

    assign w_latched_pending = w_pending[r_code];

    // Ack takes precedence over withdrawal; ACKED gives commit one cycle to clear MIE.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state         <= ST_IDLE;
            r_code          <= 4'd0;
            r_has_interrupt <= 1'b0;
            r_mcause        <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pending != 32'd0) begin
                        r_state         <= ST_REQ;
                        r_code          <= w_best_code;
                        r_has_interrupt <= 1'b1;
                        r_mcause        <= {1'b1, 27'b0, w_best_code};
                    end
                end
                ST_REQ: begin
                    if (commit_intif_ack) begin
                        r_state         <= ST_ACKED;
                        r_has_interrupt <= 1'b0;
                        r_mcause        <= 32'd0;
                    end else if (!w_latched_pending) begin
                        r_state         <= ST_IDLE;
                        r_has_interrupt <= 1'b0;
                        r_mcause        <= 32'd0;
                    end
                end
                ST_ACKED: begin
                    r_state         <= ST_IDLE;
                    r_has_interrupt <= 1'b0;
                    r_mcause        <= 32'd0;
                end
                default: begin
                    r_state         <= ST_IDLE;
                    r_has_interrupt <= 1'b0;
                    r_mcause        <= 32'd0;
                end
            endcase
        end
    end

    assign intif_csrf_mip_data        = w_mip;
    assign intif_commit_has_interrupt = r_has_interrupt;
    assign intif_commit_mcause_data   = r_mcause;

endmodule
`default_nettype wire

// File: tb/tb_interrupt_interface.sv
`default_nettype none
// Randomized bench for interrupt_interface against a cycle-level reference model.
module tb_interrupt_interface;

    localparam int SYNC = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        sw_req;
    logic        tm_req;
    logic        ext_req;
    logic [31:0] mie;
    logic        mstatus_mie;
    logic        ack;
    logic [31:0] mip;
    logic        has_int;
    logic [31:0] mcause;

    always #5 clk = ~clk;

    interrupt_interface #(.EXT_SYNC_STAGES(SYNC)) dut (
        .clk                        (clk),
        .rst                        (rst),
        .all_intif_int_software_req (sw_req),
        .all_intif_int_timer_req    (tm_req),
        .all_intif_int_ext_req      (ext_req),
        .csrf_intif_mie_data        (mie),
        .csrf_intif_mstatus_mie     (mstatus_mie),
        .commit_intif_ack           (ack),
        .intif_csrf_mip_data        (mip),
        .intif_commit_has_interrupt (has_int),
        .intif_commit_mcause_data   (mcause)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: source levels seen in mip, an "offered" flag with its
    // cause, and a one-cycle cooldown after a taken interrupt.
    bit m_sw, m_tm, m_ext;
    bit ext_hist[$];
    bit offered;
    bit cooldown;
    int cause;

    function automatic logic [31:0] model_mip();
        logic [31:0] v;
        v = 32'd0;
        v[3]  = m_sw;
        v[7]  = m_tm;
        v[11] = m_ext;
        return v;
    endfunction

    task automatic model_edge();
        logic [31:0] pend;
        pend = model_mip() & mie & (mstatus_mie ? 32'hFFFF_FFFF : 32'd0);
        if (!rst) begin
            m_sw = 0; m_tm = 0; m_ext = 0;
            ext_hist.delete();
            offered = 0; cooldown = 0; cause = 0;
        end else begin
            if (offered) begin
                if (ack) begin
                    offered  = 0;
                    cooldown = 1;
                end else if (!pend[cause]) begin
                    offered = 0;
                end
            end else if (cooldown) begin
                cooldown = 0;
            end else if (pend != 32'd0) begin
                offered = 1;
                if (pend[11])     cause = 11;
                else if (pend[3]) cause = 3;
                else              cause = 7;
            end
            m_sw = sw_req;
            m_tm = tm_req;
            ext_hist.push_back(ext_req);
            if (ext_hist.size() > SYNC) void'(ext_hist.pop_front());
            m_ext = (ext_hist.size() == SYNC) ? ext_hist[0] : 1'b0;
        end
    endtask

    task automatic check_outputs(input string phase);
        check_value({phase, "_mip"}, mip, model_mip());
        check_value({phase, "_has"}, {31'd0, has_int}, {31'd0, offered});
        check_value({phase, "_mcause"}, mcause, offered ? (32'h8000_0000 | 32'(cause)) : 32'd0);
    endtask

    task automatic step(input string phase);
        @(posedge clk);
        model_edge();
        #1;
        check_outputs(phase);
    endtask

    logic [31:0] mie_choices [8];

    initial begin
        mie_choices = '{32'h888, 32'h88, 32'h80, 32'h08, 32'h800, 32'h808, 32'hFFFF_FFFF, 32'h0};
        rst = 1'b0; sw_req = 1'b1; tm_req = 1'b1; ext_req = 1'b1;
        mie = 32'h888; mstatus_mie = 1'b1; ack = 1'b0;

        repeat (2) begin
            @(negedge clk);
            step("reset");
            check_value("reset_mip_zero", mip, 32'd0);
            check_value("reset_mcause_zero", mcause, 32'd0);
        end
        @(negedge clk);
        rst = 1'b1;
        step("release1");
        check_value("release1_mip", mip, 32'h88);
        @(negedge clk);
        step("release2");
        check_value("release2_mip", mip, 32'h888);

        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 7) == 0) sw_req = ~sw_req;
            if ($urandom_range(0, 7) == 0) tm_req = ~tm_req;
            if ($urandom_range(0, 7) == 0) ext_req = ~ext_req;
            if ($urandom_range(0, 11) == 0) mie = mie_choices[$urandom_range(0, 7)];
            if ($urandom_range(0, 9) == 0) mstatus_mie = ~mstatus_mie;
            ack = offered ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 7) == 0);
            rst = ($urandom_range(0, 199) != 0);
            step("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
